haar_integral_builder: RTL and testbench

HAAR_INTEGRAL_BUILDER -- requirements
Module: haar_integral_builder

---
 rtl/haar_integral_builder_if.sv | 34 +++
 rtl/haar_integral_builder.sv | 118 +++++++++++
 tb/tb_haar_integral_builder.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/haar_integral_builder_if.sv
// Pixel stream, integral buffer and frame handshake between producer and builder.
// HAAR_SQ_INTEGRAL_EN adds the sq_total signal.
interface haar_integral_builder_if #(
  parameter int WIN = 20
);
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_sof;
  logic        pix_ready;
  logic [31:0] integral_buffer [WIN*WIN];
  logic        START;
  logic        FRAME_ACK;
`ifdef HAAR_SQ_INTEGRAL_EN
  logic [31:0] sq_total;

  modport master (
    output pix_data, pix_valid, pix_sof, FRAME_ACK,
    input  pix_ready, integral_buffer, START, sq_total
  );
  modport slave (
    input  pix_data, pix_valid, pix_sof, FRAME_ACK,
    output pix_ready, integral_buffer, START, sq_total
  );
`else
  modport master (
    output pix_data, pix_valid, pix_sof, FRAME_ACK,
    input  pix_ready, integral_buffer, START
  );
  modport slave (
    input  pix_data, pix_valid, pix_sof, FRAME_ACK,
    output pix_ready, integral_buffer, START
  );
`endif
endinterface

// File: rtl/haar_integral_builder.sv
// Builds a WIN x WIN integral image from a raster pixel stream.
// HAAR_SQ_INTEGRAL_EN adds a running sum of squared pixels.
module haar_integral_builder #(
  parameter int WIN = 20
) (
  input logic Clk,
  input logic Reset,
  haar_integral_builder_if.slave bus
);
  localparam int N  = WIN * WIN;
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(WIN);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t      r_state;
  logic [CW-1:0] r_col;
  logic [CW-1:0] r_row;
  logic [31:0] r_rowsum;
  logic [31:0] r_buf [N];
  logic        r_start;
  logic        r_ready;

  logic          w_acc;
  logic          w_first;
  logic [CW-1:0] w_col;
  logic [CW-1:0] w_row;
  logic [IW-1:0] w_idx;
  logic [31:0]   w_rowsum;
  logic [31:0]   w_above;
  logic          w_last;
  logic          w_col_end;

  // A window restarts at index 0 from IDLE or on any accepted sof.
  always_comb begin
    w_acc     = bus.pix_valid & r_ready;
    w_first   = (r_state == IDLE) | bus.pix_sof;
    w_col     = w_first ? '0 : r_col;
    w_row     = w_first ? '0 : r_row;
    w_idx     = IW'(w_row) * IW'(WIN) + IW'(w_col);
    w_rowsum  = ((w_col == '0) ? 32'd0 : r_rowsum)
              + 32'(bus.pix_data);
    w_above   = (w_row == '0) ? 32'd0
              : r_buf[w_idx - IW'(WIN)];
    w_last    = (w_idx == IW'(N - 1));
    w_col_end = (w_col == CW'(WIN - 1));
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_col    <= '0;
      r_row    <= '0;
      r_rowsum <= '0;
      r_start  <= 1'b0;
      r_ready  <= 1'b1;
      for (int i = 0; i < N; i++) r_buf[i] <= '0;
    end else begin
      unique case (r_state)
        IDLE, ACCUM: begin
          if (w_acc) begin
            r_buf[w_idx] <= w_above + w_rowsum;
            r_rowsum     <= w_rowsum;
            if (w_last) begin
              r_state <= DONE;
              r_start <= 1'b1;
              r_ready <= 1'b0;
              r_col   <= '0;
              r_row   <= '0;
            end else begin
              r_state <= ACCUM;
              if (w_col_end) begin
                r_col <= '0;
                r_row <= w_row + CW'(1);
              end else begin
                r_col <= w_col + CW'(1);
                r_row <= w_row;
              end
            end
          end
        end
        DONE: begin
          if (bus.FRAME_ACK) begin
            r_state <= IDLE;
            r_start <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_start <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.pix_ready       = r_ready;
  assign bus.START           = r_start;
  assign bus.integral_buffer = r_buf;

`ifdef HAAR_SQ_INTEGRAL_EN
  logic [31:0] r_sq;
  logic [15:0] w_sq;

  assign w_sq = bus.pix_data * bus.pix_data;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_sq <= '0;
    end else if (w_acc) begin
      r_sq <= (w_first ? 32'd0 : r_sq) + 32'(w_sq);
    end
  end

  assign bus.sq_total = r_sq;
`endif
endmodule

// File: tb/tb_haar_integral_builder.sv
// Randomized self-checking bench for haar_integral_builder.
// Reference integral computed as explicit rectangle sums.
module tb_haar_integral_builder;
  localparam int WIN = 20;
  localparam int N   = WIN * WIN;

  logic Clk = 1'b0;
  logic Reset = 1'b1;

  haar_integral_builder_if #(.WIN(WIN)) bus ();

  haar_integral_builder #(.WIN(WIN)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;
  int unsigned m_pix [N];
  int unsigned m_exp [N];
  int unsigned m_sq;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Entry (r,c) is the sum of every pixel in the rectangle (0,0)..(r,c).
  task automatic model_build();
    m_sq = 0;
    for (int k = 0; k < N; k++) m_sq += m_pix[k] * m_pix[k];
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < WIN; c++) begin
        int unsigned s = 0;
        for (int i = 0; i <= r; i++)
          for (int j = 0; j <= c; j++)
            s += m_pix[i*WIN+j];
        m_exp[r*WIN+c] = s;
      end
  endtask

  task automatic check_buf(input string tag);
    for (int k = 0; k < N; k++)
      chk($sformatf("%s[%0d]", tag, k),
          bus.integral_buffer[k], m_exp[k]);
  endtask

  task automatic push(input logic [7:0] d, input logic sof,
                      input logic fack);
    int g = $urandom_range(0, 2);
    repeat (g) begin
      @(negedge Clk);
      bus.pix_valid = 1'b0;
      bus.pix_data  = 8'($urandom);
      bus.pix_sof   = 1'($urandom);
    end
    @(negedge Clk);
    chk("ready_hi", {31'd0, bus.pix_ready}, 32'd1);
    chk("start_lo", {31'd0, bus.START}, 32'd0);
    bus.pix_valid = 1'b1;
    bus.pix_data  = d;
    bus.pix_sof   = sof;
    bus.FRAME_ACK = fack;
    @(posedge Clk);
    #1;
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    bus.FRAME_ACK = 1'b0;
  endtask

  task automatic send_window(input int fack_at);
    for (int k = 0; k < N; k++)
      push(8'(m_pix[k]), (k == 0) ? 1'($urandom) : 1'b0,
           k == fack_at);
    model_build();
    @(negedge Clk);
    chk("start_hi", {31'd0, bus.START}, 32'd1);
    chk("ready_lo", {31'd0, bus.pix_ready}, 32'd0);
    check_buf("buf");
`ifdef HAAR_SQ_INTEGRAL_EN
    chk("sq_total", bus.sq_total, m_sq);
`endif
  endtask

  task automatic ack();
    repeat ($urandom_range(0, 3)) @(negedge Clk);
    @(negedge Clk);
    bus.FRAME_ACK = 1'b1;
    @(negedge Clk);
    bus.FRAME_ACK = 1'b0;
    chk("ack_start", {31'd0, bus.START}, 32'd0);
    chk("ack_ready", {31'd0, bus.pix_ready}, 32'd1);
  endtask

  task automatic fill(input int v);
    for (int k = 0; k < N; k++) m_pix[k] = v;
  endtask

  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    bus.pix_sof   = 1'b0;
    bus.FRAME_ACK = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst_start", {31'd0, bus.START}, 32'd0);
    chk("rst_ready", {31'd0, bus.pix_ready}, 32'd1);
    for (int k = 0; k < N; k++) m_exp[k] = 0;
    check_buf("rst_buf");
`ifdef HAAR_SQ_INTEGRAL_EN
    chk("rst_sq", bus.sq_total, 32'd0);
`endif
    Reset = 1'b0;

    // FRAME_ACK in IDLE is ignored
    ack();

    fill(1);
    send_window(-1);
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < WIN; c++)
        chk("ones", bus.integral_buffer[r*WIN+c],
            32'((r + 1) * (c + 1)));
    chk("ones_399", bus.integral_buffer[399], 32'd400);

    // DONE holds with pixels offered
    repeat (10) begin
      @(negedge Clk);
      bus.pix_valid = 1'b1;
      bus.pix_data  = 8'($urandom);
      bus.pix_sof   = 1'($urandom);
      @(posedge Clk);
      #1;
      chk("done_ready", {31'd0, bus.pix_ready}, 32'd0);
      chk("done_start", {31'd0, bus.START}, 32'd1);
    end
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    check_buf("done_hold");
    ack();

    fill(255);
    send_window(-1);
    chk("max_19", bus.integral_buffer[19], 32'd5100);
    chk("max_399", bus.integral_buffer[399], 32'd102000);
`ifdef HAAR_SQ_INTEGRAL_EN
    chk("max_sq", bus.sq_total, 32'd26010000);
`endif
    ack();

    // abandoned partial window, then sof restart
    for (int k = 0; k < 137; k++) push(8'd9, k == 0, 1'b0);
    fill(1);
    for (int k = 0; k < N; k++) push(8'd1, k == 0, 1'b0);
    model_build();
    @(negedge Clk);
    chk("sof_start", {31'd0, bus.START}, 32'd1);
    check_buf("sof_buf");
    chk("sof_399", bus.integral_buffer[399], 32'd400);
`ifdef HAAR_SQ_INTEGRAL_EN
    chk("sof_sq", bus.sq_total, 32'd400);
`endif
    ack();

    // reset mid-frame
    for (int k = 0; k < 250; k++) push(8'($urandom), 1'b0, 1'b0);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    chk("mid_rst_start", {31'd0, bus.START}, 32'd0);
    chk("mid_rst_e0", bus.integral_buffer[0], 32'd0);
    for (int k = 0; k < N; k++) m_exp[k] = 0;
    check_buf("mid_rst_buf");
    Reset = 1'b0;
    fill(2);
    send_window(-1);
    chk("twos_399", bus.integral_buffer[399], 32'd800);
    ack();

    // FRAME_ACK during ACCUM is ignored
    for (int k = 0; k < N; k++) m_pix[k] = $urandom_range(0, 255);
    send_window(100);
    ack();

    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < N; k++) m_pix[k] = $urandom_range(0, 255);
      send_window(-1);
      ack();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
